// File: rtl/ysyx_23060061_lsu.sv
// ysyx_23060061_lsu: single-outstanding AXI4-Lite load/store unit fed by the execute ALU.
// Optional macro LSU_BUS_ERR_EN: nonzero rresp/bresp is reported through resp_err.
module ysyx_23060061_lsu #(
    parameter int WIDTH        = 32,
    parameter bit ERR_ON_BADOP = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wen,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic [WIDTH-1:0] araddr,
    output logic             arvalid,
    input  logic             arready,
    input  logic [WIDTH-1:0] rdata,
    input  logic [1:0]       rresp,
    input  logic             rvalid,
    output logic             rready,
    output logic [WIDTH-1:0] awaddr,
    output logic             awvalid,
    input  logic             awready,
    output logic [WIDTH-1:0] wdata,
    output logic [3:0]       wstrb,
    output logic             wvalid,
    input  logic             wready,
    input  logic [1:0]       bresp,
    input  logic             bvalid,
    output logic             bready
);
    typedef enum logic [2:0] {IDLE, AR, R, W, B, RESP} state_t;

    state_t           state_q;
    logic             req_ready_q;
    logic             resp_valid_q;
    logic             resp_err_q;
    logic [WIDTH-1:0] resp_rdata_q;
    logic             arvalid_q;
    logic             rready_q;
    logic             awvalid_q;
    logic             wvalid_q;
    logic             bready_q;
    logic [WIDTH-1:0] araddr_q;
    logic [WIDTH-1:0] awaddr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [3:0]       wstrb_q;
    logic [1:0]       off_q;
    logic [2:0]       funct3_q;

    logic             req_legal;
    logic             req_misaligned;
    logic             req_bad;
    logic [2:0]       req_f3_eff;
    logic [WIDTH-1:0] req_bus_addr;
    logic             rd_bus_err;
    logic             wr_bus_err;

    function automatic logic op_legal(input logic wen, input logic [2:0] f3);
        if (wen) return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    function automatic logic [WIDTH-1:0] store_lanes(input logic [1:0] sz, input logic [WIDTH-1:0] d);
        case (sz)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Move the addressed lane down to bit 0, then extend by funct3.
    function automatic logic [WIDTH-1:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                     input logic [WIDTH-1:0] word);
        logic [WIDTH-1:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'h0, sh[7:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return word;
        endcase
    endfunction

    // With ERR_ON_BADOP cleared, an illegal code falls back to a plain word access.
    always_comb begin
        req_legal  = op_legal(req_wen, req_funct3);
        req_f3_eff = req_legal ? req_funct3 : 3'b010;
        case (req_f3_eff[1:0])
            2'b00:   req_misaligned = 1'b0;
            2'b01:   req_misaligned = req_addr[0];
            default: req_misaligned = |req_addr[1:0];
        endcase
        req_bad      = req_misaligned || (ERR_ON_BADOP && !req_legal);
        req_bus_addr = {req_addr[WIDTH-1:2], 2'b00};
    end

`ifdef LSU_BUS_ERR_EN
    assign rd_bus_err = |rresp;
    assign wr_bus_err = |bresp;
`else
    logic unused_resp;
    assign rd_bus_err  = 1'b0;
    assign wr_bus_err  = 1'b0;
    assign unused_resp = ^{rresp, bresp};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            araddr_q     <= '0;
            awaddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= 4'h0;
            off_q        <= 2'b00;
            funct3_q     <= 3'b000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        off_q       <= req_addr[1:0];
                        funct3_q    <= req_f3_eff;
                        if (req_bad) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else if (req_wen) begin
                            state_q   <= W;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            awaddr_q  <= req_bus_addr;
                            wdata_q   <= store_lanes(req_f3_eff[1:0], req_wdata);
                            wstrb_q   <= store_strb(req_f3_eff[1:0], req_addr[1:0]);
                        end else begin
                            state_q   <= AR;
                            arvalid_q <= 1'b1;
                            araddr_q  <= req_bus_addr;
                        end
                    end
                end
                AR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= R;
                    end
                end
                R: begin
                    if (rvalid) begin
                        rready_q     <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= rd_bus_err;
                        resp_rdata_q <= rd_bus_err ? '0 : load_extend(funct3_q, off_q, rdata);
                        state_q      <= RESP;
                    end
                end
                W: begin
                    // AW and W retire independently; leave once both have handshaken.
                    if (awready) awvalid_q <= 1'b0;
                    if (wready)  wvalid_q  <= 1'b0;
                    if ((!awvalid_q || awready) && (!wvalid_q || wready)) begin
                        bready_q <= 1'b1;
                        state_q  <= B;
                    end
                end
                B: begin
                    if (bvalid) begin
                        bready_q     <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= wr_bus_err;
                        resp_rdata_q <= '0;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                    req_ready_q  <= 1'b1;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign araddr     = araddr_q;
    assign arvalid    = arvalid_q;
    assign rready     = rready_q;
    assign awaddr     = awaddr_q;
    assign awvalid    = awvalid_q;
    assign wdata      = wdata_q;
    assign wstrb      = wstrb_q;
    assign wvalid     = wvalid_q;
    assign bready     = bready_q;
endmodule

// File: doc/ysyx_23060061_lsu.md
Name: ysyx_23060061_lsu

Overview:
- Load/store unit directly downstream of the execute ALU.
- Takes the ALU-computed effective address plus store data and the RV32 funct3 width code, and runs one AXI4-Lite read or write transaction on the data bus.
- For loads, returns lane-aligned, sign/zero-extended data to writeback.
- The core stalls on `req_ready`/`resp_valid`; one transaction is outstanding at a time.

Parameters:
- `WIDTH`, 32, data/address width (only 32 supported).
- `ERR_ON_BADOP`, 1, when 1 an illegal funct3 gives `resp_err`; when 0 it is treated as word access.

Ports:
- `clk` input 1: clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input 1: core request valid.
- `req_ready` output 1: unit idle, can accept a request.
- `req_wen` input 1: 1 = store, 0 = load.
- `req_funct3` input 3: RV32 width code (000 b, 001 h, 010 w, 100 bu, 101 hu).
- `req_addr` input WIDTH: effective address from the ALU.
- `req_wdata` input WIDTH: store data, unaligned, in the low bits.
- `resp_valid` output 1: one-cycle completion pulse.
- `resp_rdata` output WIDTH: extended load result; 0 for stores and errors.
- `resp_err` output 1: misaligned, illegal op, or bus error; valid with `resp_valid`.
- `araddr` output WIDTH; `arvalid` output 1; `arready` input 1: read address channel.
- `rdata` input WIDTH; `rresp` input 2; `rvalid` input 1; `rready` output 1: read data channel.
- `awaddr` output WIDTH; `awvalid` output 1; `awready` input 1: write address channel.
- `wdata` output WIDTH; `wstrb` output 4; `wvalid` output 1; `wready` input 1: write data channel.
- `bresp` input 2; `bvalid` input 1; `bready` output 1: write response channel.

Behaviour:
- Clock and reset: single clock `clk`; `rst` is synchronous and active-high.
- Reset state:
  - All valid/ready outputs are 0 except `req_ready`, which is 1.
  - `resp_rdata`, `resp_err`, address and data registers are 0.
  - FSM is in IDLE.
- FSM states: IDLE, AR, R, W, B, RESP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, latch addr, wdata, funct3 and wen; `req_ready` drops the next cycle.
  - Check alignment: h needs `addr[0]`=0; w needs `addr[1:0]`=0.
  - Check op: loads allow 000/001/010/100/101; stores allow 000/001/010.
  - Any failure goes to RESP with err=1, and no bus transaction is issued.
  - Otherwise a load goes to AR and a store goes to W.
- Bus addressing:
  - Bus addresses are word-aligned: {addr[31:2], 2'b00}.
  - All bus outputs are registered and asserted in the first cycle of AR or W.
- AR: `arvalid`=1 until `arready`; then go to R.
- R:
  - `rready`=1.
  - On `rvalid`, select the byte or halfword at `addr[1:0]` and sign- or zero-extend per funct3.
  - Capture the result and go to RESP.
- W:
  - `awvalid` and `wvalid` are raised together; each drops independently after its own handshake. AW and W may complete in either order or in the same cycle.
  - When both are done, go to B.
  - `wdata` replicates the store lanes: b gives {4{byte}}, h gives {2{half}}, w gives the word.
  - `wstrb` for b = 4'b0001 << `addr[1:0]`.
  - `wstrb` for h = 4'b0011 << `addr[1:0]`.
  - `wstrb` for w = 4'b1111.
- B: `bready`=1; on `bvalid`, go to RESP.
- RESP:
  - `resp_valid`=1 for exactly one cycle with rdata/err; then go to IDLE.
  - A new request can be accepted in the cycle after RESP.
- Latency with zero-wait slaves (arready/rvalid/awready/wready/bvalid high as soon as possible):
  - load: accept → AR(1) → R(1) → RESP = `resp_valid` 3 cycles after the accept edge;
  - store: accept → W(1) → B(1) → RESP = 3 cycles;
  - error: `resp_valid` 1 cycle after accept.
- Handshake rules:
  - `req_*` is sampled only at acceptance; changes in later cycles are ignored.
  - Any bus valid, once asserted, is held stable with constant address/data until its ready.
- Reset mid-transaction: FSM returns to IDLE and all valids drop at the next edge. The transaction is abandoned; the slave is reset by the same `rst`.
- Stall-free pulse: `resp_valid` has no backpressure; the core must consume it in that cycle.

Optional Feature:
- Macro: `LSU_BUS_ERR_EN`.
- Defined: a nonzero `rresp` or `bresp` sets `resp_err`=1, and `resp_rdata`=0 for loads.
- Undefined: `rresp`/`bresp` are ignored and `resp_err` reflects only misalignment and illegal op.

Test Plan:
- lbu from addr 0x8000_0003, slave `rdata`=0xAB12_3456, zero-wait → `araddr`=0x8000_0000; `resp_valid` 3 cycles after accept; `resp_rdata`=0x0000_00AB; `resp_err`=0.
- lh from addr 0x8000_0002, `rdata`=0x8001_7FFF → `resp_rdata`=0xFFFF_8001; lhu from the same address → 0x0000_8001.
- sb at addr 0x8000_0001 with `wdata`=0x1234_56C3, `awready` delayed 2 cycles and `wready` immediate → `wdata`=0xC3C3_C3C3; `wstrb`=4'b0010; `awvalid` held 3 cycles; `resp_valid` after `bvalid`; `resp_err`=0.
- lw at addr 0x8000_0002 → no `arvalid` ever; `resp_valid` 1 cycle after accept with `resp_err`=1 and `resp_rdata`=0. The same result holds for a store with funct3=100.
- Assert `rst` while in R with `rvalid` low, then deassert → next cycle `req_ready`=1 and `rready`=0; no `resp_valid` is produced.
- With `LSU_BUS_ERR_EN` defined, lw with `rresp`=2'b10 → `resp_err`=1 and `resp_rdata`=0. Without the macro, the same stimulus gives `resp_err`=0 and `resp_rdata` equal to `rdata`.
